// File: rtl/mac_mixer.sv
// mac_mixer: time-multiplexed vocoder mixer with one shared multiplier and a ready/valid input.
// Define MIXER_SATURATE_EN to clamp the narrowed result instead of wrapping it.
module mac_mixer #(
  parameter int N_CHANNELS = 8,
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 24,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [4:0]                  shift,
  input  logic [N_CHANNELS-1:0]       channel_mask,
  input  logic signed [IN_WIDTH-1:0]  carrier_channels  [N_CHANNELS],
  input  logic signed [IN_WIDTH-1:0]  envelope_channels [N_CHANNELS],
  output logic signed [OUT_WIDTH-1:0] mixed_out,
  output logic                        valid_out
);

  localparam int PROD_W = 2 * IN_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(N_CHANNELS);
  localparam int IDX_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHANNELS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic [4:0]                shift_q;
  logic [N_CHANNELS-1:0]     mask_q;
  logic signed [IN_WIDTH-1:0] car_q [N_CHANNELS];
  logic signed [IN_WIDTH-1:0] env_q [N_CHANNELS];

  logic                      accept;
  logic signed [IN_WIDTH-1:0] env_sh;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_shifted;
  logic signed [OUT_WIDTH-1:0] narrowed;

  assign ready_out = (state == IDLE) && !rst_in;
  assign accept    = ready_out && valid_in;

  // Single multiplier, steered by idx across the latched frame.
  always_comb begin
    env_sh = env_q[idx] >>> shift_q;
    prod   = PROD_W'(car_q[idx]) * PROD_W'(env_sh);
  end

`ifdef MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  always_comb begin
    acc_shifted = acc >>> OUT_SHIFT;
    if (acc_shifted > OUT_MAX)
      narrowed = OUT_WIDTH'(OUT_MAX);
    else if (acc_shifted < OUT_MIN)
      narrowed = OUT_WIDTH'(OUT_MIN);
    else
      narrowed = OUT_WIDTH'(acc_shifted);
  end
`else
  always_comb begin
    acc_shifted = acc >>> OUT_SHIFT;
    narrowed    = OUT_WIDTH'(acc_shifted);
  end
`endif

  // Sample payload has no reset; it is only consumed after an accept.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      car_q <= carrier_channels;
      env_q <= envelope_channels;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      shift_q   <= '0;
      mask_q    <= '0;
      mixed_out <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            shift_q <= shift;
            mask_q  <= channel_mask;
            acc     <= '0;
            idx     <= '0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (mask_q[idx])
            acc <= acc + ACC_W'(prod);
          idx <= idx + 1'b1;
          if (idx == LAST_IDX)
            state <= OUT;
        end
        OUT: begin
          mixed_out <= narrowed;
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mixer.sv
// Scoreboard bench for mac_mixer: driver pushes model results, negedge monitor pops on valid_out.
`timescale 1ns/1ps
module tb_mac_mixer;
  localparam int N   = 8;
  localparam int IW  = 32;
  localparam int OW  = 24;
  localparam int OSH = 0;
  localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OW - 1));

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic valid_in = 1'b0;
  logic ready_out;
  logic valid_out;
  logic [4:0] shift = '0;
  logic [N-1:0] channel_mask = '0;
  logic signed [IW-1:0] car [N];
  logic signed [IW-1:0] env [N];
  logic signed [OW-1:0] mixed_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic signed [OW-1:0] exp_q[$];
  int exp_cyc_q[$];

  mac_mixer #(.N_CHANNELS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .OUT_SHIFT(OSH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .shift(shift), .channel_mask(channel_mask),
    .carrier_channels(car), .envelope_channels(env),
    .mixed_out(mixed_out), .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct sum of masked products, then shift and narrow.
  function automatic logic signed [OW-1:0] model();
    longint s = 0;
    for (int i = 0; i < N; i++)
      if (channel_mask[i]) s += longint'(car[i]) * longint'(env[i] >>> shift);
    s = s >>> OSH;
`ifdef MIXER_SATURATE_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`endif
    return OW'(s);
  endfunction

  always @(negedge clk_in) begin
    if (valid_out !== 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_valid_out", valid_out, 0);
      else begin
        check("mixed_out", mixed_out, exp_q.pop_front());
        check("valid_out_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  task automatic send(input logic signed [OW-1:0] expv, input bit expect_out, input bit hold,
                      output int acc_cyc);
    int g = 0;
    acc_cyc = -1;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && g < 50) begin @(negedge clk_in); g++; end
    if (g >= 50) begin
      check("accept_timeout", ready_out, 1);
      valid_in = 1'b0;
      return;
    end
    @(posedge clk_in); #1;
    acc_cyc = cyc;
    if (expect_out) begin
      exp_q.push_back(expv);
      exp_cyc_q.push_back(cyc + N + 1);
    end
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 100) begin @(negedge clk_in); g++; end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic set_all(input int c, input int e);
    for (int i = 0; i < N; i++) begin car[i] = c; env[i] = e; end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < N; i++) begin
      car[i] = IW'($signed(24'($urandom)));
      env[i] = $urandom;
    end
    channel_mask = N'($urandom);
    shift = 5'($urandom);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, lo, acc_t [4];
    logic signed [OW-1:0] e3, b2b [4];
    set_all(0, 0);

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_mixed_out", mixed_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_out", ready_out, 0);
    rst_in = 1'b0; #1;
    check("ready_after_release", ready_out, 1);

    // 1: uniform frame and ready-low window
    set_all(1000, 256); shift = 8; channel_mask = 8'hFF;
    send(24'sd8000, 1, 0, t);
    lo = 0;
    @(negedge clk_in);
    while (ready_out === 1'b0 && lo < 40) begin lo++; @(negedge clk_in); end
    check("ready_low_cycles", lo, 9);
    drain();

    // 2: legacy 7-channel sum, channel 7 masked off
    set_all(100, 768); shift = 8; channel_mask = 8'h7F;
    send(24'sd2100, 1, 0, t);
    car[7] = 1000000;
    send(24'sd2100, 1, 0, t);
    drain();

    // 3: overflow of the output width
    set_all(-5000, -4096); shift = 4; channel_mask = 8'hFF;
`ifdef MIXER_SATURATE_EN
    e3 = 24'sd8388607;
`else
    e3 = -24'sd6537216;
`endif
    send(e3, 1, 0, t);
    drain();

    // 4: large shift of a negative envelope, and the empty mask
    randomize_frame();
    car[0] = 7; env[0] = -1; shift = 31; channel_mask = 8'h01;
    send(-24'sd7, 1, 0, t);
    channel_mask = 8'h00;
    send(24'sd0, 1, 0, t);
    drain();

    // 5a: inputs and valid_in disturbed during ACCUM
    randomize_frame();
    send(model(), 1, 0, t);
    repeat (5) begin
      @(negedge clk_in);
      valid_in = 1'($urandom);
      randomize_frame();
    end
    valid_in = 1'b0;
    drain();

    // 5b: reset at T+4 aborts the frame
    randomize_frame();
    send(model(), 0, 0, t);
    repeat (4) @(negedge clk_in);
    rst_in = 1'b1; #1;
    check("ready_in_reset", ready_out, 0);
    @(negedge clk_in);
    check("abort_mixed_out", mixed_out, 0);
    check("abort_valid_out", valid_out, 0);
    rst_in = 1'b0; #1;
    check("abort_ready_release", ready_out, 1);
    repeat (12) @(negedge clk_in);
    check("abort_mixed_hold", mixed_out, 0);

    // 6: back-to-back with valid_in held
    for (int k = 0; k < 4; k++) begin
      randomize_frame();
      b2b[k] = model();
      send(b2b[k], 1, (k < 3), acc_t[k]);
    end
    for (int k = 1; k < 4; k++) check("b2b_spacing", acc_t[k] - acc_t[k-1], N + 2);
    drain();

    // Random frames with random gaps and holds
    for (int k = 0; k < 25; k++) begin
      randomize_frame();
      send(model(), 1, 1'($urandom), t);
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk_in);
      end
    end
    valid_in = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
